// File: rtl/buzzer_pkg.sv
// Shared types and default sizing for the buzzer scheduler and its arbiter.
package buzzer_pkg;

  localparam int unsigned BZ_N           = 8;
  localparam int unsigned BZ_SLOT_CYCLES = 16;
  localparam int unsigned BZ_GAP_CYCLES  = 4;
  localparam int unsigned BZ_TONE_DIV    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    GAP  = 2'd2
  } bz_state_t;

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Sensor/buzzer pin bundle between the tile pins and the scheduler.
interface buzzer_scheduler_if
  import buzzer_pkg::*;
#(
  parameter int unsigned N = BZ_N
);
  localparam int unsigned IW = $clog2(N);

  logic          ena;
  logic [N-1:0]  sensor_in;
  logic [N-1:0]  buzz_en;
  logic          tone_out;
  logic [IW-1:0] active_idx;
  logic          busy;

  modport master (
    output ena, sensor_in,
    input  buzz_en, tone_out, active_idx, busy
  );

  modport slave (
    input  ena, sensor_in,
    output buzz_en, tone_out, active_idx, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned N = BZ_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx_k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx_k     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_k = IW'((32'(ptr) + k) % N);
      if (!any && req[idx_k]) begin
        any              = 1'b1;
        grant_idx        = idx_k;
        grant[idx_k]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/buzzer_scheduler.sv
// Time-slices one piezo tone driver across N sensor channels: sync, latch rises,
// round-robin grant, fixed buzzing slot, then a silent gap.
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int unsigned N           = BZ_N,
  parameter int unsigned SLOT_CYCLES = BZ_SLOT_CYCLES,
  parameter int unsigned GAP_CYCLES  = BZ_GAP_CYCLES,
  parameter int unsigned TONE_DIV    = BZ_TONE_DIV
) (
  input  logic              clk,
  input  logic              rst,
  buzzer_scheduler_if.slave bus
);
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned MAXC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned TW   = $clog2(TONE_DIV + 1);

  logic [N-1:0]  meta_q, sync_q, sync_prev_q, pending_q, pending_d;
  logic [N-1:0]  rise, req, grant, clr;
  logic [IW-1:0] grant_idx;
  logic          grant_any;

  bz_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tdiv_q, tdiv_d;
  logic [N-1:0]  buzz_q, buzz_d;
  logic          tone_q, tone_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  assign rise = sync_q & ~sync_prev_q;
  assign req  = sync_q | pending_q;

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tdiv_d  = tdiv_q;
    buzz_d  = buzz_q;
    tone_d  = tone_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    clr     = '0;

    if (!bus.ena) begin
      state_d = IDLE;
      buzz_d  = '0;
      tone_d  = 1'b0;
      idx_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          buzz_d = '0;
          tone_d = 1'b0;
          idx_d  = '0;
          busy_d = 1'b0;
          if (grant_any) begin
            state_d = SLOT;
            cnt_d   = CW'(SLOT_CYCLES - 1);
            tdiv_d  = TW'(TONE_DIV - 1);
            buzz_d  = grant;
            idx_d   = grant_idx;
            busy_d  = 1'b1;
          end
        end
        SLOT: begin
          if (cnt_q == '0) begin
            clr     = buzz_q;
            ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
            buzz_d  = '0;
            tone_d  = 1'b0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (tdiv_q == '0) begin
              tone_d = ~tone_q;
              tdiv_d = TW'(TONE_DIV - 1);
            end else begin
              tdiv_d = tdiv_q - TW'(1);
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          buzz_d  = '0;
          tone_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end

    // A fresh rise outranks the completion clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      pending_q   <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      tdiv_q      <= '0;
      buzz_q      <= '0;
      tone_q      <= 1'b0;
      idx_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      meta_q      <= bus.sensor_in;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      pending_q   <= pending_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tdiv_q      <= tdiv_d;
      buzz_q      <= buzz_d;
      tone_q      <= tone_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.buzz_en    = buzz_q;
  assign bus.tone_out   = tone_q;
  assign bus.active_idx = idx_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: stimulus queues expected grants, a
// negedge monitor checks each slot, its tone pattern and the following gap.
module tb_buzzer_scheduler;

  logic clk;
  logic rst;

  buzzer_scheduler_if bus ();

  buzzer_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] buzz;
    logic [2:0] idx;
    int         silent;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input int act, input int req_v);
    n_checks++;
    if (act != req_v) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req_v);
    end
  endtask

  task automatic push(input logic [7:0] b, input int idx, input int silent);
    exp_t e;
    e.buzz   = b;
    e.idx    = 3'(idx);
    e.silent = silent;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor state
  logic       in_slot   = 1'b0;
  logic       gap_track = 1'b0;
  logic       slot_ok   = 1'b1;
  logic       gap_ok    = 1'b1;
  int         slot_len  = 0;
  int         gap_len   = 0;
  int         silent    = -1;
  logic [7:0] cur_buzz  = '0;
  logic [2:0] cur_idx   = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_slot   = 1'b0;
      gap_track = 1'b0;
      silent    = -1;
    end else if (bus.buzz_en != '0) begin
      if (!in_slot) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_slot", int'(bus.buzz_en), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant_buzz_en", int'(bus.buzz_en), int'(e.buzz));
          chk("grant_active_idx", int'(bus.active_idx), int'(e.idx));
          if (e.silent >= 0) chk("silent_between_slots", silent, e.silent);
        end
        in_slot   = 1'b1;
        gap_track = 1'b0;
        slot_len  = 0;
        slot_ok   = 1'b1;
        cur_buzz  = bus.buzz_en;
        cur_idx   = bus.active_idx;
      end
      if (bus.buzz_en != cur_buzz || bus.active_idx != cur_idx || !bus.busy ||
          bus.tone_out != 1'(((slot_len / 4) % 2)))
        slot_ok = 1'b0;
      slot_len++;
    end else begin
      if (in_slot) begin
        chk("slot_length", slot_len, 16);
        chk("slot_tone_pattern", int'(slot_ok), 1);
        in_slot   = 1'b0;
        gap_track = 1'b1;
        gap_len   = 0;
        gap_ok    = 1'b1;
        silent    = 0;
      end
      if (silent >= 0) silent++;
      if (gap_track) begin
        if (bus.busy) begin
          gap_len++;
          if (bus.tone_out) gap_ok = 1'b0;
        end else begin
          chk("gap_length", gap_len, 4);
          chk("gap_silent", int'(gap_ok), 1);
          gap_track = 1'b0;
        end
      end
    end
  end

  initial begin
    logic saw;
    rst           = 1'b1;
    bus.ena       = 1'b1;
    bus.sensor_in = '0;
    tick(3);
    chk("reset_buzz_en", int'(bus.buzz_en), 0);
    chk("reset_tone_out", int'(bus.tone_out), 0);
    chk("reset_active_idx", int'(bus.active_idx), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_pending", int'(dut.pending_q), 0);
    rst = 1'b0;
    tick(2);

    // Reset mid-slot on ch3, then ch0 from a clean pointer
    push(8'h08, 3, -1);
    bus.sensor_in = 8'h08;
    tick(1);
    bus.sensor_in = 8'h00;
    tick(6);
    chk("midslot_pre_buzz", int'(bus.buzz_en), 8);
    rst = 1'b1;
    tick(1);
    chk("midslot_rst_buzz", int'(bus.buzz_en), 0);
    chk("midslot_rst_tone", int'(bus.tone_out), 0);
    chk("midslot_rst_busy", int'(bus.busy), 0);
    chk("midslot_rst_pending", int'(dut.pending_q), 0);
    rst = 1'b0;
    push(8'h01, 0, -1);
    bus.sensor_in = 8'h01;
    tick(1);
    bus.sensor_in = 8'h00;
    tick(35);
    chk("after_rst_drain", exp_q.size(), 0);

    // Single pulse: latency of three edges, one slot only
    push(8'h01, 0, -1);
    bus.sensor_in = 8'h01;
    tick(1);
    bus.sensor_in = 8'h00;
    tick(1);
    chk("latency_k2_buzz", int'(bus.buzz_en), 0);
    tick(1);
    chk("latency_k3_buzz", int'(bus.buzz_en), 1);
    tick(40);
    chk("single_pulse_drain", exp_q.size(), 0);

    // Held 0x06 for 200 clocks: 10 alternating slots starting at ch1
    for (int m = 0; m < 10; m++)
      push((m % 2 == 0) ? 8'h02 : 8'h04, (m % 2 == 0) ? 1 : 2, (m == 0) ? -1 : 5);
    bus.sensor_in = 8'h06;
    tick(200);
    bus.sensor_in = 8'h00;
    tick(40);
    chk("round_robin_drain", exp_q.size(), 0);

    // Pointer wrap: ch7, then held 0x81 serves ch0 then ch7
    push(8'h80, 7, -1);
    bus.sensor_in = 8'h80;
    tick(1);
    bus.sensor_in = 8'h00;
    tick(30);
    push(8'h01, 0, -1);
    push(8'h80, 7, 5);
    bus.sensor_in = 8'h81;
    tick(30);
    bus.sensor_in = 8'h00;
    tick(40);
    chk("wrap_drain", exp_q.size(), 0);

    // All channels pulsed once: ch0..ch7, idle 167 clocks after first grant
    for (int i = 0; i < 8; i++) push(8'(1 << i), i, (i == 0) ? -1 : 5);
    bus.sensor_in = 8'hFF;
    tick(1);
    bus.sensor_in = 8'h00;
    tick(168);
    chk("all_busy_before_end", int'(bus.busy), 1);
    tick(1);
    chk("all_busy_end", int'(bus.busy), 0);
    chk("all_buzz_end", int'(bus.buzz_en), 0);
    chk("all_pending_end", int'(dut.pending_q), 0);
    chk("all_drain", exp_q.size(), 0);
    tick(5);

    // Enable gating: ch5 pulse latched while disabled, served once after
    bus.ena = 1'b0;
    tick(2);
    bus.sensor_in = 8'h20;
    tick(1);
    bus.sensor_in = 8'h00;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.buzz_en != '0 || bus.busy) saw = 1'b1;
    end
    chk("ena_low_silent", int'(saw), 0);
    chk("ena_low_pending5", int'(dut.pending_q[5]), 1);
    push(8'h20, 5, -1);
    bus.ena = 1'b1;
    tick(40);
    chk("ena_drain", exp_q.size(), 0);
    chk("ena_pending_cleared", int'(dut.pending_q), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
